// File: rtl/vigna_core_v2.sv
// vigna_core_v2: multi-cycle RV32I/RV32E core with valid/ready instruction and
// data buses, byte-lane sub-word load/store and a precise trap port.
module vigna_core_v2 #(
  parameter logic [31:0] RESET_ADDR        = 32'h0000_0000,
  parameter logic [31:0] TRAP_ADDR         = 32'h0000_0100,
  parameter int unsigned NUM_REGS          = 32,
  parameter bit          MISALIGN_TRAP     = 1'b1,
  parameter bit          STACK_RESET_EN    = 1'b0,
  parameter logic [31:0] STACK_RESET_VALUE = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        i_valid,
  input  logic        i_ready,
  output logic [31:0] i_addr,
  input  logic [31:0] i_rdata,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [31:0] d_addr,
  input  logic [31:0] d_rdata,
  output logic [31:0] d_wdata,
  output logic [3:0]  d_wstrb,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] trap_pc
);

  localparam int unsigned RIDX_W = $clog2(NUM_REGS);
  localparam logic [5:0]  NREG6  = 6'(NUM_REGS);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_TRAP} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_regs [NUM_REGS];

  logic [6:0]  w_opcode, w_f7;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;
  logic [31:0] w_i_imm, w_s_imm, w_b_imm, w_u_imm, w_j_imm;
  logic [31:0] w_rs1v, w_rs2v;

  assign w_opcode = r_ir[6:0];
  assign w_rd     = r_ir[11:7];
  assign w_f3     = r_ir[14:12];
  assign w_rs1    = r_ir[19:15];
  assign w_rs2    = r_ir[24:20];
  assign w_f7     = r_ir[31:25];
  assign w_i_imm  = {{20{r_ir[31]}}, r_ir[31:20]};
  assign w_s_imm  = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
  assign w_b_imm  = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
  assign w_u_imm  = {r_ir[31:12], 12'b0};
  assign w_j_imm  = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
  assign w_rs1v   = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1[RIDX_W-1:0]];
  assign w_rs2v   = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2[RIDX_W-1:0]];
  assign i_addr   = r_pc;

  // Legality decode and register-field usage per instruction format
  logic w_legal, w_uses_rd, w_uses_rs1, w_uses_rs2, w_illegal;
  always_comb begin
    w_legal    = 1'b0;
    w_uses_rd  = 1'b0;
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    case (w_opcode)
      OP_LUI, OP_AUIPC, OP_JAL: begin
        w_legal   = 1'b1;
        w_uses_rd = 1'b1;
      end
      OP_JALR: begin
        w_legal    = (w_f3 == 3'b000);
        w_uses_rd  = 1'b1;
        w_uses_rs1 = 1'b1;
      end
      OP_BRANCH: begin
        w_legal    = (w_f3 != 3'b010) && (w_f3 != 3'b011);
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      OP_LOAD: begin
        w_legal    = w_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        w_uses_rd  = 1'b1;
        w_uses_rs1 = 1'b1;
      end
      OP_STORE: begin
        w_legal    = w_f3 inside {3'b000, 3'b001, 3'b010};
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      OP_IMM: begin
        if (w_f3 == 3'b001)      w_legal = (w_f7 == 7'b0000000);
        else if (w_f3 == 3'b101) w_legal = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
        else                     w_legal = 1'b1;
        w_uses_rd  = 1'b1;
        w_uses_rs1 = 1'b1;
      end
      OP_REG: begin
        w_legal    = (w_f7 == 7'b0000000) ||
                     ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
        w_uses_rd  = 1'b1;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      OP_FENCE: w_legal = (w_f3 == 3'b000);
      default:  w_legal = 1'b0;
    endcase
    w_illegal = !w_legal ||
                (w_uses_rd  && ({1'b0, w_rd}  >= NREG6)) ||
                (w_uses_rs1 && ({1'b0, w_rs1} >= NREG6)) ||
                (w_uses_rs2 && ({1'b0, w_rs2} >= NREG6));
  end

  // Effective address, alignment and store lane steering
  logic        w_is_load, w_is_store, w_is_mem, w_mis;
  logic [31:0] w_ea, w_wdata;
  logic [1:0]  w_ea_lo;
  logic [3:0]  w_strb_base, w_wstrb;
  always_comb begin
    w_is_load   = (w_opcode == OP_LOAD);
    w_is_store  = (w_opcode == OP_STORE);
    w_is_mem    = w_is_load || w_is_store;
    w_ea        = w_rs1v + (w_is_store ? w_s_imm : w_i_imm);
    w_mis       = 1'b0;
    w_ea_lo     = w_ea[1:0];
    w_strb_base = 4'b1111;
    w_wdata     = w_rs2v;
    case (w_f3[1:0])
      2'b00: begin
        w_strb_base = 4'b0001;
        w_wdata     = {4{w_rs2v[7:0]}};
      end
      2'b01: begin
        w_mis       = w_ea[0];
        w_ea_lo     = {w_ea[1], 1'b0};
        w_strb_base = 4'b0011;
        w_wdata     = {2{w_rs2v[15:0]}};
      end
      default: begin
        w_mis   = |w_ea[1:0];
        w_ea_lo = 2'b00;
      end
    endcase
    w_wstrb = 4'(w_strb_base << w_ea_lo);
  end

  // ALU, branch resolution, next pc and rd result
  logic [31:0] w_op_b, w_alu, w_result, w_next_pc, w_pc_nxt;
  logic [4:0]  w_shamt;
  logic        w_eq, w_lt, w_ltu, w_taken, w_redirect, w_tgt_mis, w_writes_rd;
  always_comb begin
    w_op_b  = (w_opcode == OP_REG) ? w_rs2v : w_i_imm;
    w_shamt = w_op_b[4:0];
    case (w_f3)
      3'b000:  w_alu = ((w_opcode == OP_REG) && w_f7[5]) ? w_rs1v - w_op_b : w_rs1v + w_op_b;
      3'b001:  w_alu = w_rs1v << w_shamt;
      3'b010:  w_alu = {31'd0, $signed(w_rs1v) < $signed(w_op_b)};
      3'b011:  w_alu = {31'd0, w_rs1v < w_op_b};
      3'b100:  w_alu = w_rs1v ^ w_op_b;
      3'b101:  w_alu = w_f7[5] ? 32'($signed(w_rs1v) >>> w_shamt) : w_rs1v >> w_shamt;
      3'b110:  w_alu = w_rs1v | w_op_b;
      default: w_alu = w_rs1v & w_op_b;
    endcase
    w_eq  = (w_rs1v == w_rs2v);
    w_lt  = $signed(w_rs1v) < $signed(w_rs2v);
    w_ltu = w_rs1v < w_rs2v;
    case (w_f3)
      3'b000:  w_taken = w_eq;
      3'b001:  w_taken = !w_eq;
      3'b100:  w_taken = w_lt;
      3'b101:  w_taken = !w_lt;
      3'b110:  w_taken = w_ltu;
      3'b111:  w_taken = !w_ltu;
      default: w_taken = 1'b0;
    endcase
    w_redirect = 1'b1;
    case (w_opcode)
      OP_JAL:    w_next_pc = r_pc + w_j_imm;
      OP_JALR:   w_next_pc = (w_rs1v + w_i_imm) & ~32'd1;
      OP_BRANCH: begin
        w_redirect = w_taken;
        w_next_pc  = w_taken ? r_pc + w_b_imm : r_pc + 32'd4;
      end
      default: begin
        w_redirect = 1'b0;
        w_next_pc  = r_pc + 32'd4;
      end
    endcase
    w_tgt_mis = w_redirect && w_next_pc[1];
    // low bits cleared: either the trap fires, or the target is forced aligned
    w_pc_nxt  = w_next_pc & ~32'd3;
    w_writes_rd = 1'b1;
    case (w_opcode)
      OP_LUI:          w_result = w_u_imm;
      OP_AUIPC:        w_result = r_pc + w_u_imm;
      OP_JAL, OP_JALR: w_result = r_pc + 32'd4;
      OP_IMM, OP_REG:  w_result = w_alu;
      default: begin
        w_result    = w_alu;
        w_writes_rd = 1'b0;
      end
    endcase
  end

  // Load data alignment and extension
  logic [31:0] w_ld_sh, w_ld_val;
  always_comb begin
    w_ld_sh = d_rdata >> {r_addr_lo, 3'b000};
    case (w_f3)
      3'b000:  w_ld_val = {{24{w_ld_sh[7]}}, w_ld_sh[7:0]};
      3'b001:  w_ld_val = {{16{w_ld_sh[15]}}, w_ld_sh[15:0]};
      3'b100:  w_ld_val = {24'd0, w_ld_sh[7:0]};
      3'b101:  w_ld_val = {16'd0, w_ld_sh[15:0]};
      default: w_ld_val = w_ld_sh;
    endcase
  end

  // Register-file write port select
  logic        w_rf_we;
  logic [31:0] w_rf_wdata;
  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_wdata = w_result;
    if ((r_state == S_EXEC) && w_writes_rd && !(MISALIGN_TRAP && w_tgt_mis)) begin
      w_rf_we = 1'b1;
    end else if ((r_state == S_MEM) && d_valid && d_ready && w_is_load) begin
      w_rf_we    = 1'b1;
      w_rf_wdata = w_ld_val;
    end
    if (!resetn || (w_rd == 5'd0)) w_rf_we = 1'b0;
  end

  // Register file; only the stack pointer has an optional reset value
  always_ff @(posedge clk) begin
    if (!resetn) begin
      if (STACK_RESET_EN) r_regs[2] <= STACK_RESET_VALUE;
    end else if (w_rf_we) begin
      r_regs[w_rd[RIDX_W-1:0]] <= w_rf_wdata;
    end
  end

  // Control FSM with registered bus and trap outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_ADDR;
      r_ir       <= 32'd0;
      r_addr_lo  <= 2'd0;
      i_valid    <= 1'b0;
      d_valid    <= 1'b0;
      d_addr     <= 32'd0;
      d_wdata    <= 32'd0;
      d_wstrb    <= 4'd0;
      trap       <= 1'b0;
      trap_cause <= 2'd0;
      trap_pc    <= 32'd0;
    end else begin
      trap <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (!i_valid) begin
            i_valid <= 1'b1;
          end else if (i_ready) begin
            i_valid <= 1'b0;
            r_ir    <= i_rdata;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (w_illegal) begin
            trap       <= 1'b1;
            trap_cause <= 2'd0;
            trap_pc    <= r_pc;
            r_state    <= S_TRAP;
          end else if (w_is_mem && MISALIGN_TRAP && w_mis) begin
            trap       <= 1'b1;
            trap_cause <= w_is_store ? 2'd3 : 2'd2;
            trap_pc    <= r_pc;
            r_state    <= S_TRAP;
          end else if (w_is_mem) begin
            d_valid   <= 1'b1;
            d_addr    <= w_ea & ~32'd3;
            d_wstrb   <= w_is_store ? w_wstrb : 4'd0;
            d_wdata   <= w_wdata;
            r_addr_lo <= w_ea_lo;
            r_state   <= S_MEM;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (MISALIGN_TRAP && w_tgt_mis) begin
            trap       <= 1'b1;
            trap_cause <= 2'd1;
            trap_pc    <= r_pc;
            r_state    <= S_TRAP;
          end else begin
            r_pc    <= w_pc_nxt;
            r_state <= S_FETCH;
          end
        end
        S_MEM: begin
          if (d_ready) begin
            d_valid <= 1'b0;
            r_pc    <= r_pc + 32'd4;
            r_state <= S_FETCH;
          end
        end
        S_TRAP: begin
          r_pc    <= TRAP_ADDR;
          r_state <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_vigna_core_v2.sv
// Directed bench for vigna_core_v2: a table of instructions with the bus
// activity each one must produce, plus a reset-during-access sequence.
module tb_vigna_core_v2;

  localparam logic [31:0] RST = 32'h0000_0080;
  localparam logic [31:0] TRP = 32'h0000_0100;
  localparam logic [6:0]  OPI = 7'b0010011;
  localparam logic [6:0]  OPR = 7'b0110011;
  localparam logic [6:0]  OPL = 7'b0000011;
  localparam logic [6:0]  OPJR = 7'b1100111;
  localparam int K_ALU = 0, K_ST = 1, K_LD = 2, K_TRAP = 3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_valid, i_ready;
  logic [31:0] i_addr, i_rdata;
  logic        d_valid, d_ready;
  logic [31:0] d_addr, d_rdata, d_wdata;
  logic [3:0]  d_wstrb;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] trap_pc;

  int total = 0;
  int bad   = 0;

  vigna_core_v2 #(
    .RESET_ADDR(RST), .TRAP_ADDR(TRP), .NUM_REGS(16), .MISALIGN_TRAP(1'b1),
    .STACK_RESET_EN(1'b0), .STACK_RESET_VALUE(32'h0000_1000)
  ) dut (
    .clk(clk), .resetn(resetn),
    .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_rdata(d_rdata),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .trap(trap), .trap_cause(trap_cause), .trap_pc(trap_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    int          kind;
    int          i_stall;
    int          d_stall;
    logic [31:0] rdata;
    logic [31:0] daddr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [1:0]  cause;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc, input int kind,
                              input int is, input int ds, input logic [31:0] rdata,
                              input logic [31:0] daddr, input logic [3:0] strb,
                              input logic [31:0] wdata, input logic [1:0] cause);
    vec_t v;
    v.instr = instr; v.pc = pc; v.kind = kind; v.i_stall = is; v.d_stall = ds;
    v.rdata = rdata; v.daddr = daddr; v.strb = strb; v.wdata = wdata; v.cause = cause;
    return v;
  endfunction

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input int rs1, input logic [2:0] f3,
                                        input int rd, input logic [6:0] op);
    return {imm[11:0], 5'(rs1), f3, 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), OPR};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm, input int rs2, input int rs1,
                                        input logic [2:0] f3);
    return {imm[11:5], 5'(rs2), 5'(rs1), f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input int rs2, input int rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'(rs2), 5'(rs1), f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm, input int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'(rd), 7'b1101111};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] instr, input logic [31:0] pc, input int stall,
                       output int lat);
    int n = 0;
    while (i_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    lat = n;
    chk("fetch_valid", 32'(i_valid), 32'd1);
    if (i_valid === 1'b1) begin
      chk("i_addr", i_addr, pc);
      chk("one_bus_i", 32'(d_valid), 32'd0);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        chk("i_hold_valid", 32'(i_valid), 32'd1);
        chk("i_hold_addr", i_addr, pc);
      end
      i_rdata = instr;
      i_ready = 1'b1;
      @(negedge clk);
      i_ready = 1'b0;
      i_rdata = 32'd0;
      chk("i_drop", 32'(i_valid), 32'd0);
    end
  endtask

  task automatic dside(input logic is_store, input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] wdata, input logic [31:0] rdata, input int stall);
    int n = 0;
    while (d_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("d_valid", 32'(d_valid), 32'd1);
    if (d_valid === 1'b1) begin
      chk("one_bus_d", 32'(i_valid), 32'd0);
      chk("d_addr", d_addr, addr);
      chk("d_wstrb", 32'(d_wstrb), 32'(strb));
      if (is_store) chk("d_wdata", d_wdata, wdata);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        chk("d_hold_valid", 32'(d_valid), 32'd1);
        chk("d_hold_addr", d_addr, addr);
        chk("d_hold_wstrb", 32'(d_wstrb), 32'(strb));
        if (is_store) chk("d_hold_wdata", d_wdata, wdata);
      end
      d_rdata = rdata;
      d_ready = 1'b1;
      @(negedge clk);
      d_ready = 1'b0;
      d_rdata = 32'd0;
      chk("d_drop", 32'(d_valid), 32'd0);
    end
  endtask

  task automatic trapchk(input logic [1:0] cause, input logic [31:0] pc);
    int   n     = 0;
    logic saw_d = 1'b0;
    while (trap !== 1'b1 && n < 20) begin
      if (d_valid === 1'b1) saw_d = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("trap_seen", 32'(trap), 32'd1);
    chk("trap_no_dbus", 32'(saw_d | d_valid), 32'd0);
    chk("trap_cause", 32'(trap_cause), 32'(cause));
    chk("trap_pc", trap_pc, pc);
    @(negedge clk);
    chk("trap_pulse", 32'(trap), 32'd0);
  endtask

  initial begin
    int lat;
    int prev_kind;
    int n;

    // program: x1=5, x2=10, sub-word stores/loads, traps, branches, jumps, shifts
    vecs.push_back(mk(enc_i(32'd5, 0, 3'b000, 1, OPI),        32'h080, K_ALU, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(enc_r(7'd0, 1, 1, 3'b000, 2),           32'h084, K_ALU, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(enc_s(32'd0, 2, 0, 3'b010),             32'h088, K_ST, 0, 0, 0, 32'h0, 4'b1111, 32'h0000000A, 0));
    vecs.push_back(mk(enc_i(32'hAB, 0, 3'b000, 3, OPI),       32'h08C, K_ALU, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(enc_s(32'd1, 3, 0, 3'b000),             32'h090, K_ST, 0, 5, 0, 32'h0, 4'b0010, 32'hABABABAB, 0));
    vecs.push_back(mk(enc_i(32'd3, 0, 3'b000, 4, OPL),        32'h094, K_LD, 0, 0, 32'h80000000, 32'h0, 4'b0000, 0, 0));
    vecs.push_back(mk(enc_s(32'd8, 4, 0, 3'b010),             32'h098, K_ST, 0, 0, 0, 32'h8, 4'b1111, 32'hFFFFFF80, 0));
    vecs.push_back(mk(enc_i(32'd2, 0, 3'b101, 4, OPL),        32'h09C, K_LD, 0, 0, 32'h80000000, 32'h0, 4'b0000, 0, 0));
    vecs.push_back(mk(enc_s(32'd6, 4, 0, 3'b001),             32'h0A0, K_ST, 0, 0, 0, 32'h4, 4'b1100, 32'h80008000, 0));
    vecs.push_back(mk(enc_i(32'h55, 0, 3'b000, 5, OPI),       32'h0A4, K_ALU, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(enc_i(32'd2, 0, 3'b010, 5, OPL),        32'h0A8, K_TRAP, 0, 0, 0, 0, 0, 0, 2'd2));
    vecs.push_back(mk(enc_s(32'd0, 5, 0, 3'b010),             32'h100, K_ST, 0, 0, 0, 32'h0, 4'b1111, 32'h00000055, 0));
    vecs.push_back(mk(32'h0000_0000,                          32'h104, K_TRAP, 0, 0, 0, 0, 0, 0, 2'd0));
    vecs.push_back(mk(enc_i(32'd1, 0, 3'b000, 20, OPI),       32'h100, K_TRAP, 5, 0, 0, 0, 0, 0, 2'd0));
    vecs.push_back(mk(enc_b(32'd8, 0, 0, 3'b000),             32'h100, K_ALU, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(enc_i(32'h201, 0, 3'b000, 6, OPI),      32'h108, K_ALU, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(enc_i(32'd0, 6, 3'b000, 1, OPJR),       32'h10C, K_ALU, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(enc_s(32'd4, 1, 0, 3'b010),             32'h200, K_ST, 0, 0, 0, 32'h4, 4'b1111, 32'h00000110, 0));
    vecs.push_back(mk(enc_b(32'd8, 0, 0, 3'b001),             32'h204, K_ALU, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(enc_i(32'hFFFFFFF0, 0, 3'b000, 7, OPI), 32'h208, K_ALU, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(enc_i(32'h402, 7, 3'b101, 8, OPI),      32'h20C, K_ALU, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(enc_s(32'd12, 8, 0, 3'b010),            32'h210, K_ST, 0, 0, 0, 32'hC, 4'b1111, 32'hFFFFFFFC, 0));
    vecs.push_back(mk(enc_r(7'd0, 0, 7, 3'b010, 9),           32'h214, K_ALU, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(enc_r(7'd0, 9, 7, 3'b101, 12),          32'h218, K_ALU, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(enc_s(32'd16, 12, 0, 3'b010),           32'h21C, K_ST, 0, 0, 0, 32'h10, 4'b1111, 32'h7FFFFFF8, 0));
    vecs.push_back(mk(enc_s(32'd2, 9, 0, 3'b001),             32'h220, K_ST, 0, 0, 0, 32'h0, 4'b1100, 32'h00010001, 0));
    vecs.push_back(mk(enc_j(32'd6, 1),                        32'h224, K_TRAP, 0, 0, 0, 0, 0, 0, 2'd1));
    vecs.push_back(mk(enc_s(32'd20, 1, 0, 3'b010),            32'h100, K_ST, 0, 0, 0, 32'h14, 4'b1111, 32'h00000110, 0));
    vecs.push_back(mk(enc_r(7'b0000001, 1, 1, 3'b000, 1),     32'h104, K_TRAP, 0, 0, 0, 0, 0, 0, 2'd0));

    resetn  = 1'b0;
    i_ready = 1'b0;
    i_rdata = 32'd0;
    d_ready = 1'b0;
    d_rdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_i_valid", 32'(i_valid), 32'd0);
    chk("rst_d_valid", 32'(d_valid), 32'd0);
    chk("rst_d_addr", d_addr, 32'd0);
    chk("rst_d_wdata", d_wdata, 32'd0);
    chk("rst_d_wstrb", 32'(d_wstrb), 32'd0);
    chk("rst_trap", 32'(trap), 32'd0);
    chk("rst_trap_cause", 32'(trap_cause), 32'd0);
    chk("rst_trap_pc", trap_pc, 32'd0);
    chk("rst_i_addr", i_addr, RST);
    resetn = 1'b1;

    prev_kind = -1;
    foreach (vecs[i]) begin
      fetch(vecs[i].instr, vecs[i].pc, vecs[i].i_stall, lat);
      if (prev_kind == K_ALU) chk("alu_latency", 32'(lat), 32'd3);
      case (vecs[i].kind)
        K_ST:   dside(1'b1, vecs[i].daddr, vecs[i].strb, vecs[i].wdata, 32'd0, vecs[i].d_stall);
        K_LD:   dside(1'b0, vecs[i].daddr, vecs[i].strb, 32'd0, vecs[i].rdata, vecs[i].d_stall);
        K_TRAP: trapchk(vecs[i].cause, vecs[i].pc);
        default: ;
      endcase
      prev_kind = vecs[i].kind;
    end

    // reset while a load is waiting for d_ready abandons it and refetches from RESET_ADDR
    fetch(enc_i(32'd0, 0, 3'b010, 5, OPL), TRP, 0, lat);
    n = 0;
    while (d_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mem_wait_valid", 32'(d_valid), 32'd1);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("rst_mid_d_valid", 32'(d_valid), 32'd0);
    chk("rst_mid_i_valid", 32'(i_valid), 32'd0);
    resetn = 1'b1;
    fetch(enc_i(32'd5, 0, 3'b000, 1, OPI), RST, 0, lat);
    chk("rst_refetch_trap", 32'(trap), 32'd0);
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
